// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
// The FIFO entry pairs each instruction word with the PC it was fetched from.
package fetch_pkg;

    localparam int PC_W       = 32;
    localparam int INST_W     = 32;
    localparam int INST_BYTES = 4;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } fetch_entry_t;

    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return pc & ~(PC_W'(INST_BYTES - 1));
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {instruction, PC} entries.
// Flush wins over push; the storage array itself is never reset.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees the slot, so a full FIFO may still accept a push.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential PC generation, credit-limited memory requests,
// in-order response buffering and redirect with discard of in-flight responses.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_ADDR = 32'h0000_0000,
    parameter int              DEPTH      = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic              o_imem_req_valid,
    output logic [PC_W-1:0]   o_imem_req_addr,
    input  logic              i_imem_req_ready,
    input  logic              i_imem_rsp_valid,
    input  logic [INST_W-1:0] i_imem_rsp_data,
    input  logic              i_redirect,
    input  logic [PC_W-1:0]   i_redirect_pc,
    output logic              o_inst_valid,
    output logic [INST_W-1:0] o_inst,
    output logic [PC_W-1:0]   o_inst_pc,
    input  logic              i_inst_ready
);

    localparam int              CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]     CAP     = (CW+1)'(DEPTH);
    localparam logic [PC_W-1:0] PC_STEP = PC_W'(INST_BYTES);

    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] rsp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     in_use;
    logic            fifo_full;
    logic            fifo_empty;
    logic            req_fire;
    logic            rsp_keep;
    logic            pop;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;

    // Buffered plus in-flight (including doomed) fetches never exceed DEPTH,
    // so every kept response is guaranteed a FIFO slot.
    assign in_use           = {1'b0, fifo_count} + {1'b0, outstanding};
    assign o_imem_req_valid = !i_rst && !i_redirect && (in_use < CAP);
    assign o_imem_req_addr  = fetch_pc;
    assign req_fire         = o_imem_req_valid && i_imem_req_ready;

    assign rsp_keep        = i_imem_rsp_valid && (drop == '0) && !i_redirect;
    assign push_entry.inst = i_imem_rsp_data;
    assign push_entry.pc   = rsp_pc;

    assign o_inst_valid = !i_rst && !fifo_empty;
    assign pop          = o_inst_valid && i_inst_ready;
    assign o_inst       = head_entry.inst;
    assign o_inst_pc    = head_entry.pc;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc    <= RESET_ADDR;
            rsp_pc      <= RESET_ADDR;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(i_imem_rsp_valid);
            if (i_redirect) begin
                fetch_pc <= align_pc(i_redirect_pc);
                rsp_pc   <= align_pc(i_redirect_pc);
                drop     <= outstanding - CW'(i_imem_rsp_valid);
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
                if (rsp_keep) rsp_pc   <= rsp_pc + PC_STEP;
                if (i_imem_rsp_valid && (drop != '0)) drop <= drop - CW'(1);
            end
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (rsp_keep),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (i_redirect),
        .head      (head_entry),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Environment contract and internal overflow guard.
    a_rsp_outstanding: assert property (@(posedge i_clk) disable iff (i_rst)
        i_imem_rsp_valid |-> (outstanding != '0));
    a_no_redirect_in_reset: assert property (@(posedge i_clk)
        !(i_redirect && i_rst));
    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
        (rsp_keep && fifo_full) |-> pop);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model (in-flight fetches tagged
// killed on redirect, output queue of {inst, pc}) plus directed literal checks.
module tb_fetch_unit;

    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
    localparam int          DEPTH      = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    fetch_unit #(.RESET_ADDR(RESET_ADDR), .DEPTH(DEPTH)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .o_imem_req_valid (req_valid),
        .o_imem_req_addr  (req_addr),
        .i_imem_req_ready (req_ready),
        .i_imem_rsp_valid (rsp_valid),
        .i_imem_rsp_data  (rsp_data),
        .i_redirect       (redirect),
        .i_redirect_pc    (redirect_pc),
        .o_inst_valid     (inst_valid),
        .o_inst           (inst),
        .o_inst_pc        (inst_pc),
        .i_inst_ready     (inst_ready)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_acc  = 0;

    int p_req_ready = 100;
    int p_inst_ready = 100;
    int p_rsp = 100;
    int lat_lo = 1;
    int lat_hi = 1;

    bit          f_rst = 1'b1;
    bit          f_redir = 1'b0;
    logic [31:0] f_pc = '0;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; bit killed; } fl_t;
    typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;

    mreq_t       memq[$];
    fl_t         inflight[$];
    ent_t        outq[$];
    logic [31:0] m_fetch_pc = RESET_ADDR;
    logic [31:0] acc_addrs[$];
    logic [31:0] out_pcs[$];

    logic        s_req_valid, s_inst_valid, s_rsp_valid;
    logic [31:0] s_req_addr, s_inst_pc, s_inst;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hC0DE_5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_idx(input string name, input logic [31:0] q[$], input int idx,
                             input logic [31:0] exp);
        if (idx < q.size()) check(name, q[idx], exp);
        else begin
            n_vec++;
            n_fail++;
            $display("FAIL %s: entry %0d missing, expected %08h", name, idx, exp);
        end
    endtask

    // Reference model: compare this cycle's outputs, then advance on the edge's events.
    always @(negedge clk) begin : cmp
        bit   e_req;
        bit   e_inst;
        fl_t  f;
        ent_t e;
        e_req  = !rst && !redirect && (outq.size() + inflight.size() < DEPTH);
        e_inst = !rst && (outq.size() != 0);
        check_b("req_valid", req_valid, e_req);
        if (e_req && req_valid) check("req_addr", req_addr, m_fetch_pc);
        check_b("inst_valid", inst_valid, e_inst);
        if (e_inst && inst_valid) begin
            check("inst", inst, outq[0].inst);
            check("inst_pc", inst_pc, outq[0].pc);
        end
        if (rst) begin
            inflight.delete();
            outq.delete();
            m_fetch_pc = RESET_ADDR;
        end else begin
            if (e_inst && inst_ready) e = outq.pop_front();
            if (rsp_valid) begin
                check_b("rsp_has_request", inflight.size() != 0, 1'b1);
                if (inflight.size() != 0) begin
                    f = inflight.pop_front();
                    if (!f.killed && !redirect) outq.push_back('{mem_word(f.pc), f.pc});
                end
            end
            if (redirect) begin
                outq.delete();
                foreach (inflight[i]) inflight[i].killed = 1'b1;
                m_fetch_pc = {redirect_pc[31:2], 2'b00};
            end else if (e_req && req_ready) begin
                inflight.push_back('{m_fetch_pc, 1'b0});
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end
    end

    task automatic set_knobs(input int rr, input int ir, input int lo, input int hi, input int pr);
        p_req_ready = rr; p_inst_ready = ir; lat_lo = lo; lat_hi = hi; p_rsp = pr;
    endtask

    // One clock cycle: drive inputs and the memory side, snapshot outputs mid-cycle.
    task automatic tick();
        mreq_t m;
        rst         = f_rst;
        redirect    = f_redir;
        redirect_pc = f_pc;
        req_ready   = ($urandom_range(99) < p_req_ready);
        inst_ready  = ($urandom_range(99) < p_inst_ready);
        rsp_valid   = 1'b0;
        rsp_data    = $urandom();
        if (f_rst) memq.delete();
        else if (memq.size() != 0 && memq[0].due <= cyc && $urandom_range(99) < p_rsp) begin
            m         = memq.pop_front();
            rsp_valid = 1'b1;
            rsp_data  = mem_word(m.addr);
        end
        @(negedge clk);
        s_req_valid  = req_valid;
        s_req_addr   = req_addr;
        s_inst_valid = inst_valid;
        s_inst_pc    = inst_pc;
        s_inst       = inst;
        s_rsp_valid  = rsp_valid;
        if (req_valid && req_ready) begin
            memq.push_back('{req_addr, cyc + int'($urandom_range(lat_hi, lat_lo))});
            acc_addrs.push_back(req_addr);
            n_acc++;
        end
        if (inst_valid && inst_ready) out_pcs.push_back(inst_pc);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        f_rst = 1'b1;
        repeat (n) tick();
        f_rst = 1'b0;
    endtask

    task automatic wait_inst(input string name, input logic [31:0] pc);
        for (int n = 0; n < 20 && !s_inst_valid; n++) tick();
        if (s_inst_valid) begin
            check({name, "_pc"}, s_inst_pc, pc);
            check({name, "_inst"}, s_inst, mem_word(pc));
        end else begin
            n_vec++;
            n_fail++;
            $display("FAIL %s: no instruction within 20 cycles, expected pc %08h", name, pc);
        end
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; req_ready = 1'b0;
        inst_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
        @(posedge clk);
        #1;

        // Streaming: sequential requests and outputs, first request right after reset.
        set_knobs(100, 100, 1, 1, 100);
        do_reset(2);
        check_b("rst_req_valid", s_req_valid, 1'b0);
        check_b("rst_inst_valid", s_inst_valid, 1'b0);
        acc_addrs.delete();
        out_pcs.delete();
        tick();
        check_b("first_req_valid", s_req_valid, 1'b1);
        check("first_req_addr", s_req_addr, RESET_ADDR);
        repeat (9) tick();
        for (int k = 0; k < 4; k++) begin
            check_idx("seq_req_addr", acc_addrs, k, RESET_ADDR + 32'(4 * k));
            check_idx("seq_inst_pc", out_pcs, k, RESET_ADDR + 32'(4 * k));
        end

        // Decoder stalled: credit stops at DEPTH, one pop frees one request.
        set_knobs(100, 0, 1, 1, 100);
        do_reset(1);
        n_acc = 0;
        repeat (10) tick();
        check("credit_accepts", n_acc, 4);
        check_b("credit_req_valid", s_req_valid, 1'b0);
        check_b("credit_inst_valid", s_inst_valid, 1'b1);
        check("credit_head_pc", s_inst_pc, RESET_ADDR);
        p_inst_ready = 100;
        tick();
        p_inst_ready = 0;
        n_acc = 0;
        acc_addrs.delete();
        repeat (6) tick();
        check("refill_accepts", n_acc, 1);
        check_idx("refill_addr", acc_addrs, 0, RESET_ADDR + 32'h10);
        check("refill_head_pc", s_inst_pc, RESET_ADDR + 32'h4);

        // Redirect with two slow responses in flight.
        set_knobs(100, 100, 3, 3, 100);
        do_reset(1);
        repeat (2) tick();
        f_redir = 1'b1; f_pc = 32'h0000_0103; p_req_ready = 0;
        tick();
        check_b("redir_no_req", s_req_valid, 1'b0);
        f_redir = 1'b0; p_req_ready = 100;
        tick();
        check_b("redir_req_valid", s_req_valid, 1'b1);
        check("redir_req_addr", s_req_addr, 32'h0000_0100);
        wait_inst("redir_first", 32'h0000_0100);

        // Response landing in the redirect cycle.
        set_knobs(100, 100, 2, 2, 100);
        do_reset(1);
        repeat (3) tick();
        f_redir = 1'b1; f_pc = 32'h0000_0200; p_req_ready = 0;
        tick();
        check_b("same_cycle_rsp_present", s_rsp_valid, 1'b1);
        f_redir = 1'b0;
        tick();
        check_b("same_cycle_no_stale", s_inst_valid, 1'b0);
        check_b("same_cycle_req_valid", s_req_valid, 1'b1);
        check("same_cycle_req_addr", s_req_addr, 32'h0000_0200);
        p_req_ready = 100;
        wait_inst("same_cycle_first", 32'h0000_0200);

        // PC wrap at the top of the address space.
        set_knobs(100, 100, 1, 1, 100);
        f_redir = 1'b1; f_pc = 32'hFFFF_FFF8;
        tick();
        f_redir = 1'b0;
        acc_addrs.delete();
        out_pcs.delete();
        repeat (12) tick();
        check_idx("wrap_req_0", acc_addrs, 0, 32'hFFFF_FFF8);
        check_idx("wrap_req_1", acc_addrs, 1, 32'hFFFF_FFFC);
        check_idx("wrap_req_2", acc_addrs, 2, 32'h0000_0000);
        check_idx("wrap_req_3", acc_addrs, 3, 32'h0000_0004);
        check_idx("wrap_pc_1", out_pcs, 1, 32'hFFFF_FFFC);
        check_idx("wrap_pc_2", out_pcs, 2, 32'h0000_0000);

        // Reset with buffered and outstanding fetches.
        set_knobs(100, 0, 6, 6, 100);
        do_reset(1);
        repeat (8) tick();
        check_b("pre_rst_buffered", s_inst_valid, 1'b1);
        check_b("pre_rst_credit_full", s_req_valid, 1'b0);
        f_rst = 1'b1;
        tick();
        check_b("mid_rst_inst_valid", s_inst_valid, 1'b0);
        check_b("mid_rst_req_valid", s_req_valid, 1'b0);
        f_rst = 1'b0;
        n_acc = 0;
        tick();
        check_b("post_rst_inst_valid", s_inst_valid, 1'b0);
        check_b("post_rst_req_valid", s_req_valid, 1'b1);
        check("post_rst_req_addr", s_req_addr, RESET_ADDR);
        repeat (8) tick();
        check("post_rst_accepts", n_acc, 4);

        // Randomized traffic: stalls, variable latency, redirects and resets.
        for (int seg = 0; seg < 30; seg++) begin
            set_knobs($urandom_range(100, 30), $urandom_range(100, 20), 1,
                      $urandom_range(6, 1), $urandom_range(100, 50));
            for (int t = 0; t < 100; t++) begin
                f_rst   = ($urandom_range(199) == 0);
                f_redir = !f_rst && ($urandom_range(99) < 4);
                f_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15))
                                                   : $urandom();
                tick();
            end
        end
        f_rst = 1'b0;
        f_redir = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
